// File: rtl/capsense_scanner.sv
// Capacitive touch scanner: discharge / float / time-to-high measurement for four pads,
// baseline calibration, hysteresis and debounce. Optional CAPSENSE_BASELINE_TRACK_EN enables slow baseline drift tracking.
//
// state     | meaning
// DISCHARGE | pads driven low, per-channel counts and done flags cleared
// RELEASE   | pads floating, counting cycles until each synchronised pad reads high
// EVALUATE  | one cycle: calibrate baselines or make debounced press decisions
// IDLE      | pads held low for the inter-scan gap
module capsense_scanner #(
    parameter int CNT_W            = 8,
    parameter int DISCHARGE_CYCLES = 64,
    parameter int SCAN_GAP         = 8192,
    parameter int THRESH           = 8,
    parameter int DEBOUNCE         = 3,
    parameter int CAL_SCANS        = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] PAD_IN,
    output logic       PAD_OE,
    output logic [3:0] PRESSED,
    output logic [3:0] PRESS_EVT,
    output logic       ANY_PRESS_EVT,
    output logic       CAL_DONE,
    output logic       SCAN_STROBE
);

    localparam logic [1:0] ST_DISCHARGE = 2'd0;
    localparam logic [1:0] ST_RELEASE   = 2'd1;
    localparam logic [1:0] ST_EVALUATE  = 2'd2;
    localparam logic [1:0] ST_IDLE      = 2'd3;

    localparam int TMR_MAX = (DISCHARGE_CYCLES > SCAN_GAP) ? DISCHARGE_CYCLES : SCAN_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE + 1);
    localparam int CAL_W   = $clog2(CAL_SCANS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   THR_PRESS = (CNT_W+1)'(THRESH);
    localparam logic [CNT_W:0]   THR_HOLD  = (CNT_W+1)'(THRESH / 2);
    localparam logic [TMR_W-1:0] TMR_DIS   = TMR_W'(DISCHARGE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_GAP   = TMR_W'(SCAN_GAP - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [CAL_W-1:0] CAL_LAST  = CAL_W'(CAL_SCANS - 1);

    logic [3:0]       sync_1, sync_2;
    logic [1:0]       state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] count [4];
    logic [CNT_W-1:0] baseline [4];
    logic [CNT_W-1:0] baseline_nxt [4];
    logic [CNT_W:0]   sum_press [4];
    logic [CNT_W:0]   sum_hold [4];
    logic [DEB_W-1:0] deb_cnt [4];
    logic [DEB_W-1:0] deb_nxt [4];
    logic [3:0]       done, done_now, raw;
    logic [3:0]       pressed_nxt, evt_nxt;
    logic [CAL_W-1:0] cal_cnt;
`ifdef CAPSENSE_BASELINE_TRACK_EN
    logic [3:0]       track_cnt;
`endif

    // A saturated counter counts as done so a missing pad cannot stall the scan.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            done_now[i] = done[i] | sync_2[i] | (count[i] == CNT_MAX);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DISCHARGE: if (timer == '0) state_nxt = ST_RELEASE;
            ST_RELEASE:   if (&done_now) state_nxt = ST_EVALUATE;
            ST_EVALUATE:  state_nxt = ST_IDLE;
            ST_IDLE:      if (timer == '0) state_nxt = ST_DISCHARGE;
            default:      state_nxt = ST_DISCHARGE;
        endcase
    end

    // Sums are one bit wider than the counts, so a large baseline makes a press unreachable.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum_press[i] = {1'b0, baseline[i]} + THR_PRESS;
            sum_hold[i]  = {1'b0, baseline[i]} + THR_HOLD;
            raw[i] = PRESSED[i] ? ({1'b0, count[i]} >= sum_hold[i])
                                : ({1'b0, count[i]} >  sum_press[i]);
        end
    end

    always_comb begin
        pressed_nxt = PRESSED;
        evt_nxt     = '0;
        for (int i = 0; i < 4; i++) begin
            deb_nxt[i]      = deb_cnt[i];
            baseline_nxt[i] = baseline[i];
            if (!CAL_DONE) begin
                if (count[i] > baseline[i]) baseline_nxt[i] = count[i];
            end else begin
                if (raw[i] != PRESSED[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        pressed_nxt[i] = raw[i];
                        evt_nxt[i]     = raw[i];
                        deb_nxt[i]     = '0;
                    end else begin
                        deb_nxt[i] = deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_nxt[i] = '0;
                end
`ifdef CAPSENSE_BASELINE_TRACK_EN
                if (track_cnt == 4'hF && !PRESSED[i] && !raw[i]) begin
                    if (count[i] > baseline[i])
                        baseline_nxt[i] = baseline[i] + CNT_W'(1);
                    else if (count[i] < baseline[i])
                        baseline_nxt[i] = baseline[i] - CNT_W'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_DISCHARGE;
            timer         <= TMR_DIS;
            sync_1        <= '0;
            sync_2        <= '0;
            done          <= '0;
            PAD_OE        <= 1'b1;
            PRESSED       <= '0;
            PRESS_EVT     <= '0;
            ANY_PRESS_EVT <= 1'b0;
            CAL_DONE      <= 1'b0;
            SCAN_STROBE   <= 1'b0;
            cal_cnt       <= '0;
`ifdef CAPSENSE_BASELINE_TRACK_EN
            track_cnt     <= '0;
`endif
            for (int i = 0; i < 4; i++) begin
                count[i]    <= '0;
                baseline[i] <= '0;
                deb_cnt[i]  <= '0;
            end
        end else begin
            sync_1        <= PAD_IN;
            sync_2        <= sync_1;
            state         <= state_nxt;
            PAD_OE        <= (state_nxt != ST_RELEASE);
            SCAN_STROBE   <= (state == ST_EVALUATE);
            PRESS_EVT     <= '0;
            ANY_PRESS_EVT <= 1'b0;

            if (state == ST_EVALUATE)
                timer <= TMR_GAP;
            else if (state == ST_IDLE && timer == '0)
                timer <= TMR_DIS;
            else if (timer != '0)
                timer <= timer - TMR_W'(1);

            case (state)
                ST_DISCHARGE: begin
                    done <= '0;
                    for (int i = 0; i < 4; i++) count[i] <= '0;
                end
                ST_RELEASE: begin
                    done <= done_now;
                    for (int i = 0; i < 4; i++) begin
                        if (!done_now[i]) count[i] <= count[i] + CNT_W'(1);
                    end
                end
                ST_EVALUATE: begin
                    for (int i = 0; i < 4; i++) baseline[i] <= baseline_nxt[i];
                    if (CAL_DONE) begin
                        PRESSED       <= pressed_nxt;
                        PRESS_EVT     <= evt_nxt;
                        ANY_PRESS_EVT <= |evt_nxt;
                        for (int i = 0; i < 4; i++) deb_cnt[i] <= deb_nxt[i];
`ifdef CAPSENSE_BASELINE_TRACK_EN
                        track_cnt <= track_cnt + 4'd1;
`endif
                    end else begin
                        cal_cnt <= cal_cnt + CAL_W'(1);
                        if (cal_cnt == CAL_LAST) CAL_DONE <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capsense_scanner.sv
// Directed bench for capsense_scanner: pad model with per-channel rise delays, table of scans
// with hand-computed press results, plus reset sequences and event totals.
module tb_capsense_scanner;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] PAD_IN = 4'b0000;
    logic       PAD_OE;
    logic [3:0] PRESSED;
    logic [3:0] PRESS_EVT;
    logic       ANY_PRESS_EVT;
    logic       CAL_DONE;
    logic       SCAN_STROBE;

    capsense_scanner #(
        .CNT_W(8), .DISCHARGE_CYCLES(8), .SCAN_GAP(16),
        .THRESH(8), .DEBOUNCE(3), .CAL_SCANS(16)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PAD_IN(PAD_IN), .PAD_OE(PAD_OE),
        .PRESSED(PRESSED), .PRESS_EVT(PRESS_EVT), .ANY_PRESS_EVT(ANY_PRESS_EVT),
        .CAL_DONE(CAL_DONE), .SCAN_STROBE(SCAN_STROBE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         r0, r1, r2, r3;
        logic [3:0] exp_pressed;
        logic [3:0] exp_evt;
        logic       exp_cal;
    } vec_t;

    vec_t vecs[$];
    int   rise[4];
    int   float_cyc = 0;
    int   last_rel = 0;
    int   evt_tot[4];
    int   any_tot = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_pre;

    // Pad rises rise[i] cycles after the first float cycle; driven low while PAD_OE=1.
    initial begin
        forever begin
            @(negedge CLK);
            if (!PAD_OE) begin
                for (int i = 0; i < 4; i++) PAD_IN[i] = (float_cyc >= rise[i]);
                float_cyc++;
            end else begin
                if (float_cyc != 0) last_rel = float_cyc;
                float_cyc = 0;
                PAD_IN = 4'b0000;
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) evt_tot[i] = 0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) if (PRESS_EVT[i]) evt_tot[i]++;
            if (ANY_PRESS_EVT) any_tot++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic add(input int r0, input int r1, input int r2, input int r3,
                       input logic [3:0] p, input logic [3:0] e, input logic c);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
        v.exp_pressed = p; v.exp_evt = e; v.exp_cal = c;
        vecs.push_back(v);
    endtask

    function automatic int rel_len(input vec_t v);
        int m, r;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            r = (i == 0) ? v.r0 : (i == 1) ? v.r1 : (i == 2) ? v.r2 : v.r3;
            r = (r + 3 > 256) ? 256 : r + 3;
            if (r > m) m = r;
        end
        return m;
    endfunction

    task automatic wait_strobe(output bit ok);
        int c;
        ok = 1'b0;
        c = 0;
        while (!ok && c < 2000) begin
            @(negedge CLK);
            if (SCAN_STROBE) ok = 1'b1;
            c++;
        end
    endtask

    task automatic apply(input int first, input int last);
        bit ok;
        for (int k = first; k < last; k++) begin
            rise[0] = vecs[k].r0; rise[1] = vecs[k].r1;
            rise[2] = vecs[k].r2; rise[3] = vecs[k].r3;
            wait_strobe(ok);
            if (!ok) begin
                check("strobe_timeout", k, 0, 1);
            end else begin
                check("pressed",  k, int'(PRESSED),       int'(vecs[k].exp_pressed));
                check("press_evt", k, int'(PRESS_EVT),    int'(vecs[k].exp_evt));
                check("any_evt",  k, int'(ANY_PRESS_EVT), int'(|vecs[k].exp_evt));
                check("cal_done", k, int'(CAL_DONE),      int'(vecs[k].exp_cal));
                check("release_len", k, last_rel,         rel_len(vecs[k]));
            end
        end
    endtask

    initial begin
        bit ok;
        int c;
        for (int i = 0; i < 4; i++) rise[i] = 10;

        // Calibration: count 12 on every channel, baseline 12.
        for (int i = 0; i < 16; i++) add(10, 10, 10, 10, 4'b0000, 4'b0000, i == 15);
        // Ch1 count 32 > 20 for three scans.
        add(10, 30, 10, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 30, 10, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 30, 10, 10, 4'b0010, 4'b0010, 1'b1);
        // Hold at exactly 16, then 17 for five scans, then 15 releases after three.
        add(10, 14, 10, 10, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) add(10, 15, 10, 10, 4'b0010, 4'b0000, 1'b1);
        add(10, 13, 10, 10, 4'b0010, 4'b0000, 1'b1);
        add(10, 13, 10, 10, 4'b0010, 4'b0000, 1'b1);
        add(10, 13, 10, 10, 4'b0000, 4'b0000, 1'b1);
        // Ch0 count 20 equals baseline+THRESH: not a press.
        for (int i = 0; i < 3; i++) add(18, 10, 10, 10, 4'b0000, 4'b0000, 1'b1);
        // Ch2 interrupted streak: debounce counter must clear.
        add(10, 10, 30, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 10, 30, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 10, 10, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 10, 30, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 10, 30, 10, 4'b0000, 4'b0000, 1'b1);
        // Ch3 never rises: saturates at 255, release lasts 256 cycles.
        add(10, 10, 10, 1000, 4'b0000, 4'b0000, 1'b1);
        add(10, 10, 10, 1000, 4'b0000, 4'b0000, 1'b1);
        add(10, 10, 10, 1000, 4'b1000, 4'b1000, 1'b1);
        add(10, 10, 10, 10, 4'b1000, 4'b0000, 1'b1);
        add(10, 10, 10, 10, 4'b1000, 4'b0000, 1'b1);
        add(10, 10, 10, 10, 4'b0000, 4'b0000, 1'b1);
        // Ch1 pressed again ahead of the mid-release reset.
        add(10, 30, 10, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 30, 10, 10, 4'b0000, 4'b0000, 1'b1);
        add(10, 30, 10, 10, 4'b0010, 4'b0010, 1'b1);
        n_pre = vecs.size();
        // After reset: full recalibration, then ch0 count 21 > 20.
        for (int i = 0; i < 16; i++) add(10, 10, 10, 10, 4'b0000, 4'b0000, i == 15);
        add(19, 10, 10, 10, 4'b0000, 4'b0000, 1'b1);
        add(19, 10, 10, 10, 4'b0000, 4'b0000, 1'b1);
        add(19, 10, 10, 10, 4'b0001, 4'b0001, 1'b1);

        repeat (3) @(negedge CLK);
        check("rst_pad_oe",  0, int'(PAD_OE),        1);
        check("rst_pressed", 0, int'(PRESSED),       0);
        check("rst_evt",     0, int'(PRESS_EVT),     0);
        check("rst_any",     0, int'(ANY_PRESS_EVT), 0);
        check("rst_cal",     0, int'(CAL_DONE),      0);
        check("rst_strobe",  0, int'(SCAN_STROBE),   0);
        RESET = 1'b0;

        apply(0, n_pre);

        for (int i = 0; i < 4; i++) rise[i] = 10;
        ok = 1'b0;
        c = 0;
        while (!ok && c < 500) begin
            @(negedge CLK);
            if (!PAD_OE) ok = 1'b1;
            c++;
        end
        check("wait_release", 1, int'(ok), 1);
        @(negedge CLK);
        check("pre_rst_pressed", 1, int'(PRESSED), 2);
        check("pre_rst_pad_oe",  1, int'(PAD_OE),  0);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_pad_oe",  1, int'(PAD_OE),      1);
        check("rst_pressed", 1, int'(PRESSED),     0);
        check("rst_cal",     1, int'(CAL_DONE),    0);
        check("rst_strobe",  1, int'(SCAN_STROBE), 0);
        RESET = 1'b0;

        apply(n_pre, vecs.size());

        repeat (5) @(negedge CLK);
        check("evt_total_ch0", 0, evt_tot[0], 1);
        check("evt_total_ch1", 1, evt_tot[1], 2);
        check("evt_total_ch2", 2, evt_tot[2], 0);
        check("evt_total_ch3", 3, evt_tot[3], 1);
        check("any_total",     0, any_tot,    4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
